// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the register-file read ports and the
// iterative multiply/divide unit, including its write-back request.
interface muldiv_unit_if #(
  parameter int W = 32
);
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]   rd;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [4:0]   wb_reg;
  logic         wb_en;

  // The unit itself.
  modport slave (
    input  start, op, a, b, rd,
    output ready, busy, done, result, wb_reg, wb_en
  );

  // The issuing side (execute-stage control / register file).
  modport master (
    output start, op, a, b, rd,
    input  ready, busy, done, result, wb_reg, wb_en
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL / MULHU / DIVU / REMU unit.
// One multiplier bit (LSB first) or one quotient bit (MSB first) per cycle,
// W iterations, then a one-cycle done/write-back pulse.
module muldiv_unit #(
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_BUSY = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic [1:0]     r_op;
  logic [4:0]     r_rd;
  logic [W-1:0]   r_a;      // multiplicand
  logic [W-1:0]   r_b;      // divisor
  logic [2*W-1:0] r_acc;    // product accumulator; low half starts as multiplier
  logic [W:0]     r_rem;    // partial remainder
  logic [W-1:0]   r_q;      // dividend shifting out / quotient shifting in

  logic           r_ready;
  logic           r_busy;
  logic           r_done;
  logic           r_wb_en;
  logic [W-1:0]   r_result;
  logic [4:0]     r_wb_reg;

  logic [W:0]     w_sum;
  logic [2*W-1:0] w_acc_nxt;
  logic [W:0]     w_shift;
  logic [W:0]     w_diff;
  logic [W:0]     w_rem_nxt;
  logic [W-1:0]   w_q_nxt;
  logic [W-1:0]   w_result;

  // One shift-add step and one restoring-division step, evaluated every cycle;
  // the final result is picked from whichever datapath the opcode selects.
  always_comb begin
    w_sum     = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : {(W+1){1'b0}});
    w_acc_nxt = {w_sum, r_acc[W-1:1]};

    // A non-negative difference (MSB clear) means the divisor fits: keep it.
    // A zero divisor always fits, giving all-ones quotient and rem = dividend.
    w_shift   = {r_rem[W-1:0], r_q[W-1]};
    w_diff    = w_shift - {1'b0, r_b};
    if (!w_diff[W]) begin
      w_rem_nxt = w_diff;
      w_q_nxt   = {r_q[W-2:0], 1'b1};
    end else begin
      w_rem_nxt = w_shift;
      w_q_nxt   = {r_q[W-2:0], 1'b0};
    end

    case (r_op)
      OP_MUL:   w_result = w_acc_nxt[W-1:0];
      OP_MULHU: w_result = w_acc_nxt[2*W-1:W];
      OP_DIVU:  w_result = w_q_nxt;
      OP_REMU:  w_result = w_rem_nxt[W-1:0];
      default:  w_result = {W{1'b0}};
    endcase
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_op     <= 2'b00;
      r_rd     <= 5'd0;
      r_a      <= {W{1'b0}};
      r_b      <= {W{1'b0}};
      r_acc    <= {(2*W){1'b0}};
      r_rem    <= {(W+1){1'b0}};
      r_q      <= {W{1'b0}};
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wb_en  <= 1'b0;
      r_result <= {W{1'b0}};
      r_wb_reg <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done  <= 1'b0;
          r_wb_en <= 1'b0;
          if (bus.start) begin
            r_op    <= bus.op;
            r_rd    <= bus.rd;
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_acc   <= {{W{1'b0}}, bus.b};
            r_rem   <= {(W+1){1'b0}};
            r_q     <= bus.a;
            r_cnt   <= {CW{1'b0}};
            r_state <= S_BUSY;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_BUSY: begin
          r_acc <= w_acc_nxt;
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (r_cnt == LAST_ITER) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_wb_en  <= (r_rd != 5'd0);
            r_result <= w_result;
            r_wb_reg <= r_rd;
          end else begin
            r_state  <= S_BUSY;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_wb_en <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_wb_en <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready  = r_ready;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.wb_en  = r_wb_en;
  assign bus.result = r_result;
  assign bus.wb_reg = r_wb_reg;

endmodule
